// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the byte-serial subtraction controller.
package sub_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/sub_seq_ctrl_sub.sv
// Combinational 8-bit subtractor with borrow-in: {B_out, D} = A - B - Bin.
module sub_8bit_bin
  import sub_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic              Bin,
  output logic [BYTE_W-1:0] D,
  output logic              B_out
);

  logic [BYTE_W:0] full;

  assign full  = {1'b0, A} - {1'b0, B} - {{BYTE_W{1'b0}}, Bin};
  assign D     = full[BYTE_W-1:0];
  assign B_out = full[BYTE_W];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Byte-serial multi-word subtraction controller, LSB byte first, one shared 8-bit subtractor.
// Optional build macro SUB_SEQ_SAT_EN: saturate d to zero on underflow (b_out still reports it).
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one byte per cycle through the shared subtractor
// DONE  | result presented, held until out_ready
module sub_seq_ctrl
  import sub_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] d,
  output logic                     b_out,
  output logic                     busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     d_q;

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] diff_byte;
  logic              bout_byte;
  logic              last_byte;

  assign a_byte    = a_q[BYTE_W*int'(idx) +: BYTE_W];
  assign b_byte    = b_q[BYTE_W*int'(idx) +: BYTE_W];
  assign last_byte = (idx == LAST_IDX);

  sub_8bit_bin u_sub (
    .A    (a_byte),
    .B    (b_byte),
    .Bin  (borrow),
    .D    (diff_byte),
    .B_out(bout_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      borrow <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            idx    <= '0;
            borrow <= 1'b0;
            d_q    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          borrow <= bout_byte;
          d_q[BYTE_W*int'(idx) +: BYTE_W] <= diff_byte;
          if (last_byte) begin
`ifdef SUB_SEQ_SAT_EN
            // Underflow clamps the whole word; the final byte write is overridden.
            if (bout_byte) d_q <= '0;
`endif
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == DONE);
  assign d         = d_q;
  assign b_out     = borrow;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed self-checking bench for sub_seq_ctrl with NBYTES = 4.
module tb_sub_seq_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int NPAIRS = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         b_out;
  logic         busy;

  int total = 0;
  int bad   = 0;

  sub_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .b_out    (b_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y};
`ifdef SUB_SEQ_SAT_EN
    if (r[W]) r[W-1:0] = '0;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair from IDLE, then count edges until out_valid (bounded).
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b);
    int lat;
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    total++;
    if (lat !== NBYTES) begin
      bad++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, lat, NBYTES);
    end
    total++;
    if (d !== exp_d) begin
      bad++;
      $display("FAIL %s_d got=%h exp=%h", name, d, exp_d);
    end
    total++;
    if (b_out !== exp_b) begin
      bad++;
      $display("FAIL %s_b_out got=%b exp=%b", name, b_out, exp_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #1;
    total++;
    if ({in_ready, out_valid, busy, b_out} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=1000", {in_ready, out_valid, busy, b_out});
    end
    total++;
    if (d !== '0) begin
      bad++;
      $display("FAIL reset_d got=%h exp=0", d);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [W:0] r;
    out_ready = 1'b1;
    run_op("basic", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0);
    step();
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL basic_release got=%b exp=100", {in_ready, out_valid, busy});
    end
    run_op("ripple", 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0);
    step();
    r = ref_sub(32'h0, 32'h1);
`ifdef SUB_SEQ_SAT_EN
    run_op("underflow", 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1);
`else
    run_op("underflow", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
`endif
    step();
    run_op("equal_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    step();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    run_op("hold", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a = 32'hDEAD_BEEF;
      b = 32'h0000_0001;
      in_valid = 1'b1;
      step();
      total++;
      if ({out_valid, in_ready, b_out} !== 3'b100 || d !== 32'h7FFF_FFFF) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got v/r/bo=%b d=%h exp 100 d=7fffffff",
                 i, {out_valid, in_ready, b_out}, d);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      bad++;
      $display("FAIL hold_not_taken got=%b exp=100", {in_ready, busy, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_before got=%b exp=1", busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, b_out, in_ready} !== 4'b0001 || d !== '0) begin
      bad++;
      $display("FAIL midrst_abort got v/busy/bo/rdy=%b d=%h exp 0001 d=0",
               {out_valid, busy, b_out, in_ready}, d);
    end
    #2;
    rst = 1'b0;
    step();
    run_op("after_rst", 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa [NPAIRS];
    logic [W-1:0] pb [NPAIRS];
    logic [W:0]   q [$];
    logic [W:0]   exp_r;
    logic         hs_in;
    logic         hs_out;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    for (int i = 0; i < NPAIRS; i++) begin
      pa[i] = $urandom();
      pb[i] = $urandom();
    end
    pa[0] = 32'h0000_0000; pb[0] = 32'hFFFF_FFFF;
    pa[1] = 32'hFFFF_FFFF; pb[1] = 32'h0000_0000;
    a = pa[0];
    b = pb[0];
    in_valid = 1'b1;
    while (got < NPAIRS && cyc < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra_result got d=%h exp none", d);
        end else begin
          exp_r = q.pop_front();
          if ({b_out, d} !== exp_r) begin
            bad++;
            $display("FAIL b2b_result n=%0d got=%h exp=%h", got, {b_out, d}, exp_r);
          end
        end
        got++;
      end
      step();
      cyc++;
      if (hs_in) begin
        q.push_back(ref_sub(pa[sent], pb[sent]));
        sent++;
        if (sent < NPAIRS) begin
          a = pa[sent];
          b = pb[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    total++;
    if (got !== NPAIRS || sent !== NPAIRS) begin
      bad++;
      $display("FAIL b2b_count got=%0d sent=%0d exp=%0d", got, sent, NPAIRS);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL b2b_drained got=%b exp=001", {out_valid, busy, in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
